mem_port_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch and data load/store traffic.
- Sequences each access as request, grant, then response; this is what drives the load stall and the store wait seen by the decoder.
- Generates byte enables, right-justifies read data, and extends read data per access size.
- Sits between the fetch unit / load-store path and the memory.
- At most one outstanding memory transaction.

---
 rtl/mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store traffic. Each access runs request -> grant -> response,
// with at most one transaction outstanding. Byte enables and lane-replicated
// store data are produced here. Load data is right-justified and then
// zero- or sign-extended to the access size.
// Optional build macro MEM_PORT_ARBITER_RR_EN: round-robin arbitration
// between data and fetch. When it is undefined, data has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LAT_MAX = 15
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [1:0]        d_acc_i,
  input  logic              d_sext_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Word-align mask: the memory only ever sees word addresses.
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  // The timeout fires on the last RESP cycle that fits inside MEM_LAT_MAX.
  localparam logic [3:0]        LAT_LAST  = 4'(MEM_LAT_MAX - 32'sd1);
  localparam logic [31:0]       NOP_INSN  = 32'h0000_0013;

  // Half accesses need an even address. Word accesses and the unused size
  // code 3 need a word-aligned address.
  function automatic logic f_misaligned(input logic [1:0] acc, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (acc)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      default: mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

  // Byte lanes touched by the access.
  function automatic logic [3:0] f_be(input logic [1:0] acc, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    case (acc)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the memory can take it from any lane.
  function automatic logic [31:0] f_wdata(input logic [1:0] acc, input logic [31:0] wdata);
    logic [31:0] wd;
    wd = wdata;
    case (acc)
      2'd0:    wd = {4{wdata[7:0]}};
      2'd1:    wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  // Right-justify the addressed lanes, then extend to 32 bits.
  function automatic logic [31:0] f_load(input logic [1:0]  acc,
                                         input logic [1:0]  off,
                                         input logic        sext,
                                         input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    logic        fill;
    sh   = rdata >> {off, 3'b000};
    fill = 1'b0;
    res  = sh;
    case (acc)
      2'd0: begin
        fill = sext & sh[7];
        res  = {{24{fill}}, sh[7:0]};
      end
      2'd1: begin
        fill = sext & sh[15];
        res  = {{16{fill}}, sh[15:0]};
      end
      default: res = sh;
    endcase
    return res;
  endfunction

  state_t            r_state,      w_state_nxt;
  owner_t            r_owner,      w_owner_nxt;
  logic [3:0]        r_cnt,        w_cnt_nxt;
  logic [1:0]        r_off,        w_off_nxt;
  logic [1:0]        r_acc,        w_acc_nxt;
  logic              r_sext,       w_sext_nxt;
  logic              r_mem_req,    w_mem_req_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata,  w_mem_wdata_nxt;
  logic [3:0]        r_mem_be,     w_mem_be_nxt;
  logic              r_if_gnt,     w_if_gnt_nxt;
  logic              r_if_rvalid,  w_if_rvalid_nxt;
  logic [31:0]       r_if_rdata,   w_if_rdata_nxt;
  logic              r_d_gnt,      w_d_gnt_nxt;
  logic              r_d_rvalid,   w_d_rvalid_nxt;
  logic [31:0]       r_d_rdata,    w_d_rdata_nxt;
  logic              r_d_err,      w_d_err_nxt;
  logic              w_pick_d;
  logic              w_pick_if;

`ifdef MEM_PORT_ARBITER_RR_EN
  // 1 = data is favoured on the next conflict. It resets towards data.
  logic              r_prio_data;

  // Round-robin: on a conflict, the requester that was not granted last wins.
  always_comb begin
    w_pick_d = 1'b0;
    if (d_req_i && if_req_i) begin
      w_pick_d = r_prio_data;
    end else if (d_req_i) begin
      w_pick_d = 1'b1;
    end else begin
      w_pick_d = 1'b0;
    end
  end

  // Remember who was granted last so that the other requester is favoured next.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prio_data <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_pick_d) begin
        r_prio_data <= 1'b0;
      end else if (w_pick_if) begin
        r_prio_data <= 1'b1;
      end else begin
        r_prio_data <= r_prio_data;
      end
    end else begin
      r_prio_data <= r_prio_data;
    end
  end
`else
  // Fixed priority: any pending data request beats fetch.
  always_comb begin
    w_pick_d = 1'b0;
    if (d_req_i) begin
      w_pick_d = 1'b1;
    end else begin
      w_pick_d = 1'b0;
    end
  end
`endif

  assign w_pick_if = if_req_i & ~w_pick_d;

  // State register for the request/grant/response sequencer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of every registered output and latched field.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_off_nxt       = r_off;
    w_acc_nxt       = r_acc;
    w_sext_nxt      = r_sext;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_if_gnt_nxt    = 1'b0;
    w_if_rvalid_nxt = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_gnt_nxt     = 1'b0;
    w_d_rvalid_nxt  = 1'b0;
    w_d_rdata_nxt   = r_d_rdata;
    w_d_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_d) begin
          w_d_gnt_nxt = 1'b1;
          if (f_misaligned(d_acc_i, d_addr_i[1:0])) begin
            // The request is refused on the spot and the port is never used.
            w_d_err_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_REQ;
            w_owner_nxt     = OWN_D;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = d_we_i;
            w_mem_addr_nxt  = d_addr_i & ADDR_MASK;
            w_mem_wdata_nxt = f_wdata(d_acc_i, d_wdata_i);
            w_mem_be_nxt    = f_be(d_acc_i, d_addr_i[1:0]);
            w_off_nxt       = d_addr_i[1:0];
            w_acc_nxt       = d_acc_i;
            w_sext_nxt      = d_sext_i;
          end
        end else if (w_pick_if) begin
          w_if_gnt_nxt    = 1'b1;
          w_state_nxt     = ST_REQ;
          w_owner_nxt     = OWN_IF;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = if_addr_i & ADDR_MASK;
          w_mem_be_nxt    = 4'b1111;
          w_off_nxt       = 2'd0;
          w_acc_nxt       = 2'd2;
          w_sext_nxt      = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (mem_gnt_i) begin
          w_mem_req_nxt = 1'b0;
          w_cnt_nxt     = 4'd0;
          w_state_nxt   = ST_RESP;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end

      ST_RESP: begin
        if (mem_rvalid_i) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
          case (r_owner)
            OWN_D: begin
              w_d_rvalid_nxt = 1'b1;
              if (!r_mem_we) begin
                w_d_rdata_nxt = f_load(r_acc, r_off, r_sext, mem_rdata_i);
              end else begin
                w_d_rdata_nxt = r_d_rdata;
              end
            end
            OWN_IF: begin
              w_if_rvalid_nxt = 1'b1;
              w_if_rdata_nxt  = mem_rdata_i;
            end
            default: w_owner_nxt = OWN_NONE;
          endcase
        end else if (r_cnt == LAT_LAST) begin
          // The memory never answered. Release the port. A stalled fetch
          // receives a NOP so that the pipeline can drain.
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
          case (r_owner)
            OWN_D:   w_d_err_nxt = 1'b1;
            OWN_IF: begin
              w_if_rvalid_nxt = 1'b1;
              w_if_rdata_nxt  = NOP_INSN;
            end
            default: w_owner_nxt = OWN_NONE;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_owner_nxt   = OWN_NONE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // Registers for the outputs and the latched request fields.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_owner     <= OWN_NONE;
      r_cnt       <= 4'd0;
      r_off       <= 2'd0;
      r_acc       <= 2'd0;
      r_sext      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= 32'd0;
      r_d_err     <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_off       <= w_off_nxt;
      r_acc       <= w_acc_nxt;
      r_sext      <= w_sext_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_if_gnt    <= w_if_gnt_nxt;
      r_if_rvalid <= w_if_rvalid_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_gnt     <= w_d_gnt_nxt;
      r_d_rvalid  <= w_d_rvalid_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_d_err     <= w_d_err_nxt;
    end
  end

  assign if_gnt_o    = r_if_gnt;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign d_gnt_o     = r_d_gnt;
  assign d_rvalid_o  = r_d_rvalid;
  assign d_rdata_o   = r_d_rdata;
  assign d_err_o     = r_d_err;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_be_o    = r_mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases followed by
// randomized fetch/load/store traffic against a behavioural reference model.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = 32'd0;
  logic [31:0] d_wdata_i = 32'd0;
  logic [1:0]  d_acc_i = 2'd0;
  logic        d_sext_i = 1'b0;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_acc_i(d_acc_i), .d_sext_i(d_sext_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the set of byte lanes covered by [off, off+size).
  function automatic logic [3:0] m_be(input int off, input int size);
    logic [3:0] r;
    r = 4'd0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + size) r[b] = 1'b1;
    return r;
  endfunction

  // Reference model: lane b carries byte (b mod size) of the store data.
  function automatic logic [31:0] m_wdata(input logic [31:0] w, input int size);
    logic [31:0] r;
    r = 32'd0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(b % size) +: 8];
    return r;
  endfunction

  // Reference model: numeric value of the addressed bytes, optionally signed.
  function automatic logic [31:0] m_load(input logic [31:0] word, input int off,
                                         input int size, input bit sext);
    longint v, span;
    span = longint'(1) << (8 * size);
    v = (longint'(word) >> (8 * off)) % span;
    if (sext && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] addr, input logic [1:0] acc,
                          input logic sext, input logic [31:0] wdata, input logic [31:0] rword,
                          input int gdly, input int rdly, input bit give_rsp);
    int size, off, n;
    bit mis;
    size = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
    off  = int'(addr % 32'd4);
    mis  = (addr % size) != 0;
    d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_acc_i = acc;
    d_sext_i = sext; d_wdata_i = wdata;
    n = 0;
    do begin tick(); n++; end while (!d_gnt_o && n < 10);
    d_req_i = 1'b0;
    chk("d_gnt", {31'd0, d_gnt_o}, 32'd1);
    if (!d_gnt_o) return;
    chk("d_err_on_gnt", {31'd0, d_err_o}, {31'd0, mis});
    if (mis) begin
      chk("mis_no_req", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("mis_no_req_later", {31'd0, mem_req_o}, 32'd0);
      return;
    end
    chk("d_mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("d_mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
    chk("d_mem_we", {31'd0, mem_we_o}, {31'd0, we});
    chk("d_mem_be", {28'd0, mem_be_o}, {28'd0, m_be(off, size)});
    if (we) chk("d_mem_wdata", mem_wdata_o, m_wdata(wdata, size));
    repeat (gdly) tick();
    chk("d_req_held", {31'd0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("d_req_drop", {31'd0, mem_req_o}, 32'd0);
    if (give_rsp) begin
      repeat (rdly) tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = rword;
      tick();
      mem_rvalid_i = 1'b0;
      chk("d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
      chk("d_if_quiet", {31'd0, if_rvalid_o}, 32'd0);
      if (!we) chk("d_rdata", d_rdata_o, m_load(rword, off, size, sext));
    end else begin
      n = 0;
      do begin tick(); n++; end while (!d_err_o && n < 20);
      chk("d_timeout_cycles", n, 32'd15);
      chk("d_timeout_no_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    end
  endtask

  task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rword,
                           input int gdly, input int rdly, input bit give_rsp);
    int n;
    if_req_i = 1'b1; if_addr_i = addr;
    n = 0;
    do begin tick(); n++; end while (!if_gnt_o && n < 10);
    if_req_i = 1'b0;
    chk("if_gnt", {31'd0, if_gnt_o}, 32'd1);
    if (!if_gnt_o) return;
    chk("if_no_d_gnt", {31'd0, d_gnt_o}, 32'd0);
    chk("if_mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("if_mem_addr", mem_addr_o, addr);
    chk("if_mem_be", {28'd0, mem_be_o}, 32'h0000_000F);
    chk("if_mem_we", {31'd0, mem_we_o}, 32'd0);
    repeat (gdly) tick();
    chk("if_req_held", {31'd0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("if_req_drop", {31'd0, mem_req_o}, 32'd0);
    if (give_rsp) begin
      repeat (rdly) tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = rword;
      tick();
      mem_rvalid_i = 1'b0;
      chk("if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
      chk("if_rdata", if_rdata_o, rword);
      chk("if_d_quiet", {30'd0, d_rvalid_o, d_err_o}, 32'd0);
    end else begin
      n = 0;
      do begin tick(); n++; end while (!if_rvalid_o && n < 20);
      chk("if_timeout_cycles", n, 32'd15);
      chk("if_timeout_nop", if_rdata_o, 32'h0000_0013);
    end
  endtask

  initial begin
    logic [31:0] ra, rw, rd;
    logic [1:0]  racc;
    bit          exp_d;
    int          n;

    // Reset state.
    repeat (3) tick();
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_pulses", {27'd0, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o}, 32'd0);
    chk("rst_be_we", {27'd0, mem_we_o, mem_be_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    #3 rstn_i = 1'b1;

    // Directed cases.
    fetch_txn(32'h0000_0100, 32'h0050_0093, 1, 1, 1'b1);
    data_txn(1'b0, 32'h0000_0203, 2'd0, 1'b1, 32'd0, 32'h80FF_FFFF, 0, 1, 1'b1);
    chk("tp_lb_sext", d_rdata_o, 32'hFFFF_FF80);
    chk("tp_lb_be", {28'd0, mem_be_o}, 32'h0000_0008);
    data_txn(1'b0, 32'h0000_0203, 2'd0, 1'b0, 32'd0, 32'h80FF_FFFF, 0, 1, 1'b1);
    chk("tp_lb_zext", d_rdata_o, 32'h0000_0080);
    data_txn(1'b1, 32'h0000_0202, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 1, 2, 1'b1);
    chk("tp_sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
    chk("tp_sh_be", {28'd0, mem_be_o}, 32'h0000_000C);
    data_txn(1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'd0, 32'd0, 0, 0, 1'b1);

    // Both requesters held across four transactions.
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0500; d_acc_i = 2'd2; d_sext_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      n = 0;
      do begin tick(); n++; end while (!if_gnt_o && !d_gnt_o && n < 10);
      chk("arb_winner", {30'd0, d_gnt_o, if_gnt_o}, exp_d ? 32'd2 : 32'd1);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA000_0000 + k;
      tick();
      mem_rvalid_i = 1'b0;
      chk("arb_rvalid", {30'd0, d_rvalid_o, if_rvalid_o}, exp_d ? 32'd2 : 32'd1);
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();

    // Response withheld: both owners time out.
    fetch_txn(32'h0000_0600, 32'd0, 0, 0, 1'b0);
    data_txn(1'b0, 32'h0000_0700, 2'd2, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0);

    // Reset while the request is pending at the memory.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0800;
    n = 0;
    do begin tick(); n++; end while (!if_gnt_o && n < 10);
    if_req_i = 1'b0;
    chk("rst_mid_pre_req", {31'd0, mem_req_o}, 32'd1);
    #3 rstn_i = 1'b0;
    #1 chk("rst_mid_async", {31'd0, mem_req_o}, 32'd0);
    tick();
    #3 rstn_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_late_rvalid", {29'd0, if_rvalid_o, d_rvalid_o, mem_req_o}, 32'd0);
      tick();
    end

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom(); rw = $urandom(); rd = $urandom();
      racc = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)
        fetch_txn(ra & 32'hFFFF_FFFC, rd, $urandom_range(0, 3), $urandom_range(0, 5), 1'b1);
      else
        data_txn(1'($urandom_range(0, 1)), ra, racc, 1'($urandom_range(0, 1)), rw, rd,
                 $urandom_range(0, 3), $urandom_range(0, 5), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
